// File: rtl/tl_ram_responder_pkg.sv
// TileLink-UL opcodes, response-register layout and alignment helper
// shared by the tl_ram_responder slice.
package tl_pkg;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    typedef struct packed {
        logic      valid;
        d_opcode_e opcode;
        logic [3:0] size;
        logic [2:0] source;
        logic      denied;
        logic      is_read;
    } resp_t;

    // Sizes above 3 are rejected separately, so their result here is irrelevant.
    function automatic logic misaligned(input logic [3:0] size, input logic [2:0] addr_lo);
        case (size)
            4'd0:    return 1'b0;
            4'd1:    return addr_lo[0];
            4'd2:    return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/tl_ram_responder_if.sv
// TileLink-UL A/D channel bundle between an initiator (master) and the RAM responder (slave).
interface tl_ram_responder_if;
    logic        io_a_valid;
    logic        io_a_ready;
    logic [2:0]  io_a_bits_opcode;
    logic [2:0]  io_a_bits_param;
    logic [3:0]  io_a_bits_size;
    logic [2:0]  io_a_bits_source;
    logic [31:0] io_a_bits_address;
    logic [7:0]  io_a_bits_mask;
    logic [63:0] io_a_bits_data;
    logic        io_a_bits_corrupt;
    logic        io_d_valid;
    logic        io_d_ready;
    logic [2:0]  io_d_bits_opcode;
    logic [1:0]  io_d_bits_param;
    logic [3:0]  io_d_bits_size;
    logic [2:0]  io_d_bits_source;
    logic        io_d_bits_sink;
    logic        io_d_bits_denied;
    logic [63:0] io_d_bits_data;
    logic        io_d_bits_corrupt;

    modport master (
        output io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
               io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
               io_a_bits_corrupt, io_d_ready,
        input  io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
               io_d_bits_source, io_d_bits_sink, io_d_bits_denied, io_d_bits_data,
               io_d_bits_corrupt
    );

    modport slave (
        input  io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
               io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
               io_a_bits_corrupt, io_d_ready,
        output io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
               io_d_bits_source, io_d_bits_sink, io_d_bits_denied, io_d_bits_data,
               io_d_bits_corrupt
    );
endinterface

// File: rtl/tl_ram_responder_ram.sv
// DEPTH x 64 synchronous RAM: one enabled read port, one byte-masked write port.
module ram_bytemask_1r1w #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [63:0]              rdata_o,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [7:0]               wmask_i,
    input  logic [63:0]              wdata_i
);
    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (wmask_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UL slave terminating Put/Get into a byte-masked scratchpad,
// one outstanding D response, full throughput when D is not stalled.
module tl_ram_responder
    import tl_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
    parameter logic        SINK_ID   = 1'b0
) (
    input logic               clock,
    input logic               reset,
    tl_ram_responder_if.slave bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd8;

    resp_t          resp_q, resp_d;
    logic           a_ready, a_fire, d_fire;
    logic           is_put, is_get, denied;
    logic           ram_we, ram_re;
    logic [AW-1:0]  idx;
    logic [63:0]    ram_rdata;
    logic           unused_param;

    assign unused_param = ^bus.io_a_bits_param;

    assign a_ready = ~resp_q.valid | bus.io_d_ready;
    assign a_fire  = bus.io_a_valid & a_ready;
    assign d_fire  = resp_q.valid & bus.io_d_ready;
    assign is_put  = (bus.io_a_bits_opcode == PUT_FULL) || (bus.io_a_bits_opcode == PUT_PARTIAL);
    assign is_get  = (bus.io_a_bits_opcode == GET);
    assign idx     = bus.io_a_bits_address[AW+2:3];

    always_comb begin
        denied = 1'b0;
        if (!(is_put || is_get))                                         denied = 1'b1;
        if (bus.io_a_bits_size > 4'd3)                                   denied = 1'b1;
        if (misaligned(bus.io_a_bits_size, bus.io_a_bits_address[2:0]))  denied = 1'b1;
        if (bus.io_a_bits_address < BASE_ADDR)                           denied = 1'b1;
        if ({1'b0, bus.io_a_bits_address} >= LIMIT)                      denied = 1'b1;
        if (is_put && bus.io_a_bits_corrupt)                             denied = 1'b1;
    end

    // Reset gates RAM access so a request seen in the reset cycle has no side effect.
    assign ram_we = a_fire & ~reset & is_put & ~denied;
    assign ram_re = a_fire & ~reset & is_get & ~denied;

    always_comb begin
        resp_d = resp_q;
        if (a_fire) begin
            resp_d.valid   = 1'b1;
            resp_d.opcode  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            resp_d.size    = bus.io_a_bits_size;
            resp_d.source  = bus.io_a_bits_source;
            resp_d.denied  = denied;
            resp_d.is_read = is_get;
        end else if (d_fire) begin
            resp_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) resp_q <= '0;
        else       resp_q <= resp_d;
    end

    ram_bytemask_1r1w #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clock),
        .re_i    (ram_re),
        .raddr_i (idx),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .waddr_i (idx),
        .wmask_i (bus.io_a_bits_mask),
        .wdata_i (bus.io_a_bits_data)
    );

    assign bus.io_a_ready        = a_ready;
    assign bus.io_d_valid        = resp_q.valid;
    assign bus.io_d_bits_opcode  = resp_q.opcode;
    assign bus.io_d_bits_param   = '0;
    assign bus.io_d_bits_size    = resp_q.size;
    assign bus.io_d_bits_source  = resp_q.source;
    assign bus.io_d_bits_sink    = SINK_ID;
    assign bus.io_d_bits_denied  = resp_q.denied;
    assign bus.io_d_bits_data    = (resp_q.is_read & ~resp_q.denied) ? ram_rdata : '0;
    assign bus.io_d_bits_corrupt = resp_q.is_read & resp_q.denied;
endmodule

// File: tb/tb_tl_ram_responder.sv
// Directed plus randomized bench for tl_ram_responder against a queue/array reference model.
module tb_tl_ram_responder;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0800_0000;
    localparam logic        SINK  = 1'b1;

    typedef struct {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [2:0]  source;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    tl_ram_responder_if bus();

    tl_ram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .SINK_ID(SINK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    logic [63:0] mem_m [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] sz, input logic [2:0] src,
                           input logic [31:0] addr, input logic [7:0] mask,
                           input logic [63:0] data, input logic corrupt);
        bus.io_a_valid        = 1'b1;
        bus.io_a_bits_opcode  = op;
        bus.io_a_bits_param   = 3'($urandom);
        bus.io_a_bits_size    = sz;
        bus.io_a_bits_source  = src;
        bus.io_a_bits_address = addr;
        bus.io_a_bits_mask    = mask;
        bus.io_a_bits_data    = data;
        bus.io_a_bits_corrupt = corrupt;
    endtask

    task automatic idle();
        bus.io_a_valid = 1'b0;
    endtask

    // Reference: apply the access rules to the request the bench is presenting.
    task automatic model_accept();
        logic [2:0]       op  = bus.io_a_bits_opcode;
        logic [3:0]       sz  = bus.io_a_bits_size;
        longint unsigned  a   = 64'(bus.io_a_bits_address);
        bit               put = (op == 3'd0) || (op == 3'd1);
        bit               get = (op == 3'd4);
        bit               den = 1'b0;
        int unsigned      w   = 0;
        exp_t             e;
        if (!put && !get) den = 1'b1;
        if (sz > 4'd3) den = 1'b1;
        else if ((a % (64'd1 << sz)) != 0) den = 1'b1;
        if (a < 64'(BASE) || a >= 64'(BASE) + 64'(DEPTH) * 8) den = 1'b1;
        if (put && bus.io_a_bits_corrupt) den = 1'b1;
        if (!den) w = int'((a - 64'(BASE)) / 8);
        if (put && !den) begin
            for (int b = 0; b < 8; b++)
                if (bus.io_a_bits_mask[b]) mem_m[w][b*8 +: 8] = bus.io_a_bits_data[b*8 +: 8];
        end
        e.opcode  = get ? 3'd1 : 3'd0;
        e.size    = sz;
        e.source  = bus.io_a_bits_source;
        e.denied  = den;
        e.data    = (get && !den) ? mem_m[w] : 64'd0;
        e.corrupt = get && den;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("d_valid", 64'(bus.io_d_valid), 64'(exp_q.size() != 0));
        chk("a_ready", 64'(bus.io_a_ready), 64'(exp_q.size() == 0 || bus.io_d_ready));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("d_opcode",  64'(bus.io_d_bits_opcode),  64'(e.opcode));
            chk("d_size",    64'(bus.io_d_bits_size),    64'(e.size));
            chk("d_source",  64'(bus.io_d_bits_source),  64'(e.source));
            chk("d_denied",  64'(bus.io_d_bits_denied),  64'(e.denied));
            chk("d_data",    bus.io_d_bits_data,         e.data);
            chk("d_corrupt", 64'(bus.io_d_bits_corrupt), 64'(e.corrupt));
            chk("d_param",   64'(bus.io_d_bits_param),   64'd0);
            chk("d_sink",    64'(bus.io_d_bits_sink),    64'(SINK));
        end
    endtask

    // One clock: check mid-cycle, advance the model, return just after the rising edge.
    task automatic step();
        bit acc;
        @(negedge clock);
        if (!reset) check_outputs();
        acc = bus.io_a_valid && (exp_q.size() == 0 || bus.io_d_ready);
        if (exp_q.size() != 0 && bus.io_d_ready) void'(exp_q.pop_front());
        if (reset) exp_q.delete();
        else if (acc) model_accept();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [31:0] off;
        logic [31:0] addr;
        logic [63:0] keep;

        reset = 1'b1;
        bus.io_d_ready = 1'b1;
        drive_a(3'd0, 4'd0, 3'd0, 32'd0, 8'd0, 64'd0, 1'b0);
        idle();
        step();
        step();
        reset = 1'b0;

        chk("rst_d_valid", 64'(bus.io_d_valid),        64'd0);
        chk("rst_a_ready", 64'(bus.io_a_ready),        64'd1);
        chk("rst_opcode",  64'(bus.io_d_bits_opcode),  64'd0);
        chk("rst_size",    64'(bus.io_d_bits_size),    64'd0);
        chk("rst_source",  64'(bus.io_d_bits_source),  64'd0);
        chk("rst_denied",  64'(bus.io_d_bits_denied),  64'd0);
        chk("rst_data",    bus.io_d_bits_data,         64'd0);
        chk("rst_corrupt", 64'(bus.io_d_bits_corrupt), 64'd0);

        for (int i = 0; i < int'(DEPTH); i++) begin
            drive_a(3'd0, 4'd3, 3'(i), BASE + 32'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b0);
            step();
        end
        idle();
        step();

        // Put then Get on consecutive cycles (read-after-write).
        drive_a(3'd0, 4'd3, 3'd5, BASE + 32'h10, 8'hFF, 64'h1122334455667788, 1'b0);
        step();
        drive_a(3'd4, 4'd3, 3'd6, BASE + 32'h10, 8'hFF, 64'd0, 1'b0);
        step();
        chk("tp_full_data", bus.io_d_bits_data, 64'h1122334455667788);
        chk("tp_full_src",  64'(bus.io_d_bits_source), 64'd6);

        drive_a(3'd1, 4'd3, 3'd1, BASE + 32'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
        step();
        drive_a(3'd4, 4'd3, 3'd2, BASE + 32'h10, 8'hFF, 64'd0, 1'b0);
        step();
        chk("tp_partial_data", bus.io_d_bits_data, 64'h11223344_BBBBBBBB);

        drive_a(3'd4, 4'd3, 3'd3, BASE + DEPTH * 8, 8'hFF, 64'd0, 1'b0);
        step();
        chk("tp_oor_denied",  64'(bus.io_d_bits_denied),  64'd1);
        chk("tp_oor_corrupt", 64'(bus.io_d_bits_corrupt), 64'd1);
        chk("tp_oor_data",    bus.io_d_bits_data,         64'd0);
        drive_a(3'd4, 4'd2, 3'd4, BASE + 32'h2, 8'h0F, 64'd0, 1'b0);
        step();
        chk("tp_misalign_denied", 64'(bus.io_d_bits_denied), 64'd1);
        drive_a(3'd0, 4'd3, 3'd0, BASE + 32'h10, 8'hFF, 64'hDEAD, 1'b1);
        step();
        drive_a(3'd2, 4'd3, 3'd1, BASE + 32'h18, 8'hFF, 64'd0, 1'b0);
        step();
        chk("tp_badop_opcode", 64'(bus.io_d_bits_opcode), 64'd0);
        drive_a(3'd4, 4'd4, 3'd2, BASE, 8'hFF, 64'd0, 1'b0);
        step();
        drive_a(3'd0, 4'd3, 3'd3, BASE - 32'd8, 8'hFF, 64'd1, 1'b0);
        step();
        drive_a(3'd4, 4'd3, 3'd7, BASE + 32'h10, 8'hFF, 64'd0, 1'b0);
        step();
        chk("tp_after_denied_put", bus.io_d_bits_data, 64'h11223344_BBBBBBBB);
        idle();
        step();

        for (int i = 0; i < 8; i++) begin
            drive_a(3'd4, 4'd3, 3'(i), BASE + 32'(i * 16), 8'hFF, 64'd0, 1'b0);
            step();
        end
        idle();
        step();

        drive_a(3'd4, 4'd3, 3'd5, BASE + 32'h28, 8'hFF, 64'd0, 1'b0);
        step();
        drive_a(3'd4, 4'd3, 3'd6, BASE + 32'h30, 8'hFF, 64'd0, 1'b0);
        bus.io_d_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.io_d_ready = 1'b1;
        step();
        idle();
        step();
        step();

        for (int i = 0; i < 400; i++) begin
            bus.io_d_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2: op = 3'd0;
                    3, 4:    op = 3'd1;
                    9:       op = 3'($urandom_range(0, 7));
                    default: op = 3'd4;
                endcase
                sz  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                off = 32'($urandom_range(0, DEPTH * 8 + 15));
                if (sz <= 4'd3 && $urandom_range(0, 3) != 0) off = off & ~((32'd1 << sz) - 32'd1);
                addr = ($urandom_range(0, 19) == 0) ? BASE - 32'd8 : BASE + off;
                drive_a(op, sz, 3'($urandom), addr, 8'($urandom), {$urandom, $urandom},
                        ($urandom_range(0, 9) == 0));
            end
            step();
        end
        bus.io_d_ready = 1'b1;
        idle();
        step();
        step();

        // Reset with a response pending and a Put presented in the reset cycle.
        keep = 64'hCAFEF00D_01234567;
        drive_a(3'd0, 4'd3, 3'd1, BASE + 32'h20, 8'hFF, keep, 1'b0);
        step();
        drive_a(3'd4, 4'd3, 3'd2, BASE + 32'h20, 8'hFF, 64'd0, 1'b0);
        step();
        chk("pre_rst_d_valid", 64'(bus.io_d_valid), 64'd1);
        reset = 1'b1;
        drive_a(3'd0, 4'd3, 3'd3, BASE + 32'h20, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1'b0);
        step();
        reset = 1'b0;
        idle();
        chk("mid_rst_d_valid", 64'(bus.io_d_valid), 64'd0);
        chk("mid_rst_a_ready", 64'(bus.io_a_ready), 64'd1);
        step();
        drive_a(3'd4, 4'd3, 3'd4, BASE + 32'h20, 8'hFF, 64'd0, 1'b0);
        step();
        chk("post_rst_data", bus.io_d_bits_data, keep);
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
